// File: rtl/hex_page_scheduler_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// hex_page_scheduler_if : page sources, user controls and indicator outputs
// Revision: 1.0
//------------------------------------------------------------------------------
interface hex_page_scheduler_if;
  logic [127:0] pages_reg1;
  logic [127:0] pages_reg2;
  logic         key_n;
  logic [3:0]   alert_req;
  logic         rot_en;
  logic [31:0]  disp_reg1;
  logic [31:0]  disp_reg2;
  logic [1:0]   page_idx;
  logic [1:0]   mode;
  logic         blank;

  modport master (
    output pages_reg1, pages_reg2, key_n, alert_req, rot_en,
    input  disp_reg1, disp_reg2, page_idx, mode, blank
  );

  modport slave (
    input  pages_reg1, pages_reg2, key_n, alert_req, rot_en,
    output disp_reg1, disp_reg2, page_idx, mode, blank
  );
endinterface

`default_nettype wire

// File: rtl/hex_page_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// hex_page_scheduler : picks one of four status pages for the hex indicator
// (ms-tick auto-rotation, debounced manual stepping, prioritised alert preemption).
// Optional alert blink: define HEX_SCHED_BLINK_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
module hex_page_scheduler #(
  parameter int TICK_DIV       = 50000,
  parameter int DWELL_MS       = 2000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int MANUAL_HOLD_MS = 10000,
  parameter int ALERT_MIN_MS   = 500
`ifdef HEX_SCHED_BLINK_EN
  , parameter int BLINK_MS     = 250
`endif
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  hex_page_scheduler_if.slave bus
);

  localparam int TICK_W  = $clog2(TICK_DIV + 1);
  localparam int DWELL_W = $clog2(DWELL_MS + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W  = $clog2(MANUAL_HOLD_MS + 1);
  localparam int ATMR_W  = $clog2(ALERT_MIN_MS + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_MS - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MANUAL_HOLD_MS - 1);
  localparam logic [ATMR_W-1:0]  ALERT_FULL = ATMR_W'(ALERT_MIN_MS);

  typedef enum logic [1:0] {
    ST_AUTO   = 2'b00,
    ST_MANUAL = 2'b01,
    ST_ALERT  = 2'b10
  } state_t;

  // ---------------------------------------------------------------- timebase
  logic [TICK_W-1:0] presc;
  logic              tick;

  assign tick = (presc == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // ---------------------------------------------------------------- key path
  // Key state resets to "released" so leaving reset never looks like a press.
  logic             key_meta;
  logic             key_sync;
  logic             key_deb;
  logic [DEB_W-1:0] deb_cnt;
  logic             key_evt;

  assign key_evt = tick && (key_sync != key_deb) && (deb_cnt == DEB_LAST) && key_deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      key_deb  <= 1'b1;
      deb_cnt  <= '0;
    end else begin
      key_meta <= bus.key_n;
      key_sync <= key_meta;
      if (key_sync == key_deb) begin
        deb_cnt <= '0;
      end else if (tick) begin
        if (deb_cnt == DEB_LAST) begin
          key_deb <= key_sync;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- alert priority
  logic [1:0] low_idx;
  logic       alert_any;

  assign alert_any = |bus.alert_req;

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.alert_req[i]) begin
        low_idx = 2'(i);
      end
    end
  end

  // ---------------------------------------------------------------- scheduler FSM
  state_t             state;
  state_t             state_nxt;
  logic [1:0]         page;
  logic [1:0]         page_nxt;
  logic [DWELL_W-1:0] dwell;
  logic [DWELL_W-1:0] dwell_nxt;
  logic [HOLD_W-1:0]  hold;
  logic [HOLD_W-1:0]  hold_nxt;
  logic [ATMR_W-1:0]  atmr;
  logic [ATMR_W-1:0]  atmr_nxt;
  logic               dwell_done;
  logic               alert_done;

  assign dwell_done = (dwell == DWELL_LAST);
  assign alert_done = (atmr == ALERT_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_AUTO;
      page  <= 2'd0;
      dwell <= '0;
      hold  <= '0;
      atmr  <= '0;
    end else begin
      state <= state_nxt;
      page  <= page_nxt;
      dwell <= dwell_nxt;
      hold  <= hold_nxt;
      atmr  <= atmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    dwell_nxt = dwell;
    hold_nxt  = hold;
    atmr_nxt  = atmr;

    // Any alert preempts whatever else happens this cycle, including key_evt.
    if (state != ST_ALERT && alert_any) begin
      state_nxt = ST_ALERT;
      page_nxt  = low_idx;
      atmr_nxt  = '0;
    end else begin
      case (state)
        ST_AUTO: begin
          if (tick && bus.rot_en) begin
            dwell_nxt = dwell_done ? '0 : dwell + 1'b1;
          end
          if (key_evt) begin
            page_nxt  = page + 2'd1;
            state_nxt = ST_MANUAL;
            hold_nxt  = '0;
          end else if (tick && bus.rot_en && dwell_done) begin
            page_nxt = page + 2'd1;
          end
        end

        ST_MANUAL: begin
          if (key_evt) begin
            page_nxt = page + 2'd1;
            hold_nxt = '0;
          end else if (tick) begin
            if (hold == HOLD_LAST) begin
              state_nxt = ST_AUTO;
              dwell_nxt = '0;
              hold_nxt  = '0;
            end else begin
              hold_nxt = hold + 1'b1;
            end
          end
        end

        ST_ALERT: begin
          if (tick && !alert_done) begin
            atmr_nxt = atmr + 1'b1;
          end
          // A dropped active bit only hands over once the minimum hold has elapsed.
          if (!alert_any) begin
            if (alert_done) begin
              state_nxt = ST_AUTO;
              dwell_nxt = '0;
            end
          end else if ((low_idx < page) || (!bus.alert_req[page] && alert_done)) begin
            page_nxt = low_idx;
            atmr_nxt = '0;
          end
        end

        default: begin
          state_nxt = ST_AUTO;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- blink
`ifdef HEX_SCHED_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_MS + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_nxt;
  logic               blank_q;
  logic               blank_nxt;

  always_comb begin
    blank_nxt = blank_q;
    blink_nxt = blink_cnt;
    if (state_nxt != ST_ALERT || state != ST_ALERT) begin
      blank_nxt = 1'b0;
      blink_nxt = '0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blank_nxt = ~blank_q;
        blink_nxt = '0;
      end else begin
        blink_nxt = blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blank_q   <= 1'b0;
    end else begin
      blink_cnt <= blink_nxt;
      blank_q   <= blank_nxt;
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = 1'b0;
`endif

  // ---------------------------------------------------------------- datapath
  logic [31:0] disp1_q;
  logic [31:0] disp2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp1_q <= '0;
      disp2_q <= '0;
    end else begin
      disp1_q <= bus.pages_reg1[{page, 5'b0} +: 32];
      disp2_q <= bus.pages_reg2[{page, 5'b0} +: 32];
    end
  end

  assign bus.disp_reg1 = disp1_q;
  assign bus.disp_reg2 = disp2_q;
  assign bus.page_idx  = page;
  assign bus.mode      = state;

endmodule

`default_nettype wire

// File: tb/tb_hex_page_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_hex_page_scheduler : directed and randomized checks against a tick-level model
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_hex_page_scheduler;
  localparam int TICK_DIV       = 4;
  localparam int DWELL_MS       = 3;
  localparam int DEBOUNCE_MS    = 2;
  localparam int MANUAL_HOLD_MS = 5;
  localparam int ALERT_MIN_MS   = 2;
`ifdef HEX_SCHED_BLINK_EN
  localparam int BLINK_MS       = 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  hex_page_scheduler_if bus();

  hex_page_scheduler #(
    .TICK_DIV       (TICK_DIV),
    .DWELL_MS       (DWELL_MS),
    .DEBOUNCE_MS    (DEBOUNCE_MS),
    .MANUAL_HOLD_MS (MANUAL_HOLD_MS),
    .ALERT_MIN_MS   (ALERT_MIN_MS)
`ifdef HEX_SCHED_BLINK_EN
    , .BLINK_MS     (BLINK_MS)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: everything measured in ms ticks since reset (timestamps)
  int          m_cyc, m_ntick, m_run, m_mode, m_page, m_dwell;
  int          m_hold_start, m_a_start, m_blink_start;
  bit [1:0]    m_kh;
  bit          m_deb, m_blank, m_coinc;
  logic [31:0] m_d1, m_d2;

  task automatic m_reset();
    m_cyc = 0; m_ntick = 0; m_run = 0; m_mode = 0; m_page = 0; m_dwell = 0;
    m_hold_start = 0; m_a_start = 0; m_blink_start = 0;
    m_kh = 2'b11; m_deb = 1'b1; m_blank = 1'b0; m_coinc = 1'b0;
    m_d1 = '0; m_d2 = '0;
  endtask

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return 0;
  endfunction

  task automatic model_edge();
    bit tk, sync_v, evt, expire, done;
    int pre, post;
    logic [3:0] req;
    if (!rst_n) begin
      m_reset();
      return;
    end
    tk   = (m_cyc % TICK_DIV) == TICK_DIV - 1;
    pre  = m_ntick;
    post = m_ntick + (tk ? 1 : 0);
    m_d1 = bus.pages_reg1[m_page*32 +: 32];
    m_d2 = bus.pages_reg2[m_page*32 +: 32];
    // debounced level: synchronized key must differ on DEBOUNCE_MS consecutive ticks
    sync_v = m_kh[1];
    m_kh   = {m_kh[0], bus.key_n};
    evt    = 1'b0;
    if (sync_v == m_deb) m_run = 0;
    else if (tk) begin
      m_run++;
      if (m_run == DEBOUNCE_MS) begin
        m_deb = sync_v;
        m_run = 0;
        evt   = !sync_v;
      end
    end
    req     = bus.alert_req;
    m_coinc = 1'b0;
    if (m_mode != 2 && req != 4'd0) begin
      m_mode = 2; m_page = lowest(req); m_a_start = post; m_blink_start = post;
    end else if (m_mode == 2) begin
      done = (pre - m_a_start) >= ALERT_MIN_MS;
      if (req == 4'd0) begin
        if (done) begin m_mode = 0; m_dwell = 0; end
      end else if (lowest(req) < m_page || (!req[m_page] && done)) begin
        m_page = lowest(req); m_a_start = post;
      end
    end else if (m_mode == 0) begin
      expire = 1'b0;
      if (tk && bus.rot_en) begin
        m_dwell++;
        if (m_dwell == DWELL_MS) begin m_dwell = 0; expire = 1'b1; end
      end
      if (evt) begin
        m_page = (m_page + 1) % 4; m_mode = 1; m_hold_start = post; m_coinc = expire;
      end else if (expire) m_page = (m_page + 1) % 4;
    end else begin
      if (evt) begin
        m_page = (m_page + 1) % 4; m_hold_start = post;
      end else if (tk && (post - m_hold_start) >= MANUAL_HOLD_MS) begin
        m_mode = 0; m_dwell = 0;
      end
    end
`ifdef HEX_SCHED_BLINK_EN
    m_blank = (m_mode == 2) ? ((((post - m_blink_start) / BLINK_MS) % 2) == 1) : 1'b0;
`else
    m_blank = 1'b0;
`endif
    m_ntick = post;
    m_cyc++;
  endtask

  function automatic logic [68:0] expv();
    return {2'(m_page), 2'(m_mode), m_blank, m_d1, m_d2};
  endfunction

  function automatic logic [68:0] actv();
    return {bus.page_idx, bus.mode, bus.blank, bus.disp_reg1, bus.disp_reg2};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    bus.key_n = 1'b1; bus.alert_req = 4'd0; bus.rot_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (actv() !== 69'd0) begin
      errors++; $display("FAIL reset got=%h exp=0", actv());
    end
  endtask

  task automatic test_rotation();
    for (int p = 0; p < 4; p++) begin
      bus.pages_reg1[p*32 +: 32] = 32'h10 + p;
      bus.pages_reg2[p*32 +: 32] = 32'h20 + p;
    end
    do_reset();
    bus.rot_en = 1'b1;
    for (int c = 1; c <= 49; c++) begin
      cycle();
      checks++;
      if (actv() !== expv()) begin
        errors++; $display("FAIL rotation c=%0d got=%h exp=%h", c, actv(), expv());
      end
      if (c % 12 == 0) begin
        checks++;
        if (bus.page_idx !== 2'((c / 12) % 4)) begin
          errors++; $display("FAIL rotation_page c=%0d got=%0d exp=%0d", c, bus.page_idx, (c / 12) % 4);
        end
      end
      if (c % 12 == 1 && c > 1) begin
        checks++;
        if (bus.disp_reg1 !== 32'h10 + 32'((c / 12) % 4)) begin
          errors++; $display("FAIL rotation_disp c=%0d got=%h exp=%h", c, bus.disp_reg1, 32'h10 + 32'((c / 12) % 4));
        end
      end
    end
  endtask

  task automatic test_freeze();
    int pg;
    bus.rot_en = 1'b0;
    cycle();
    pg = m_page;
    for (int c = 0; c < 40; c++) begin
      cycle();
      checks++;
      if (actv() !== expv()) begin
        errors++; $display("FAIL freeze c=%0d got=%h exp=%h", c, actv(), expv());
      end
    end
    checks++;
    if (bus.page_idx !== 2'(pg)) begin
      errors++; $display("FAIL freeze_page got=%0d exp=%0d", bus.page_idx, pg);
    end
  endtask

  task automatic test_key();
    int pg;
    bus.rot_en = 1'b0;
    pg = m_page;
    for (int c = 0; c < 64; c++) begin
      bus.key_n = !((c < TICK_DIV) || (c >= 24 && c < 24 + 3 * TICK_DIV));
      cycle();
      checks++;
      if (actv() !== expv()) begin
        errors++; $display("FAIL key c=%0d got=%h exp=%h", c, actv(), expv());
      end
      if (c == 23) begin
        checks++;
        if (bus.mode !== 2'b00 || bus.page_idx !== 2'(pg)) begin
          errors++; $display("FAIL key_bounce mode=%b page=%0d exp mode=00 page=%0d", bus.mode, bus.page_idx, pg);
        end
      end
      if (c == 24 + 3 * TICK_DIV - 1) begin
        checks++;
        if (bus.mode !== 2'b01 || bus.page_idx !== 2'(pg + 1)) begin
          errors++; $display("FAIL key_press mode=%b page=%0d exp mode=01 page=%0d", bus.mode, bus.page_idx, (pg + 1) % 4);
        end
      end
    end
    checks++;
    if (bus.mode !== 2'b00 || bus.page_idx !== 2'(pg + 1)) begin
      errors++; $display("FAIL key_hold_return mode=%b page=%0d exp mode=00 page=%0d", bus.mode, bus.page_idx, (pg + 1) % 4);
    end
  endtask

  task automatic test_alert();
    bus.rot_en = 1'b0;
    bus.alert_req = 4'b1100;
    cycle();
    checks++;
    if (bus.page_idx !== 2'd2 || bus.mode !== 2'b10) begin
      errors++; $display("FAIL alert_enter page=%0d mode=%b exp page=2 mode=10", bus.page_idx, bus.mode);
    end
    bus.alert_req = 4'b0100;
    for (int c = 0; c < 24; c++) begin
      if (c == 10) bus.alert_req = 4'b0000;
      cycle();
      checks++;
      if (actv() !== expv()) begin
        errors++; $display("FAIL alert c=%0d got=%h exp=%h", c, actv(), expv());
      end
    end
    checks++;
    if (bus.page_idx !== 2'd2 || bus.mode !== 2'b00) begin
      errors++; $display("FAIL alert_exit page=%0d mode=%b exp page=2 mode=00", bus.page_idx, bus.mode);
    end
  endtask

  task automatic test_priority();
    logic [3:0] seq [5] = '{4'b0100, 4'b0110, 4'b1110, 4'b0111, 4'b0110};
    int         pgs [5] = '{2, 1, 1, 0, 0};
    for (int s = 0; s < 5; s++) begin
      bus.alert_req = seq[s];
      cycle();
      checks++;
      if (bus.page_idx !== 2'(pgs[s]) || bus.mode !== 2'b10) begin
        errors++; $display("FAIL priority s=%0d page=%0d mode=%b exp page=%0d mode=10", s, bus.page_idx, bus.mode, pgs[s]);
      end
    end
    for (int c = 0; c < 30; c++) begin
      if (c == 14) bus.alert_req = 4'b0000;
      cycle();
      checks++;
      if (actv() !== expv()) begin
        errors++; $display("FAIL priority_run c=%0d got=%h exp=%h", c, actv(), expv());
      end
      if (c == 13) begin
        checks++;
        if (bus.page_idx !== 2'd1 || bus.mode !== 2'b10) begin
          errors++; $display("FAIL priority_handover page=%0d mode=%b exp page=1 mode=10", bus.page_idx, bus.mode);
        end
      end
    end
  endtask

  task automatic test_alert_pulse();
    bus.alert_req = 4'b0001;
    cycle();
    bus.alert_req = 4'b0000;
    cycle();
    checks++;
    if (bus.page_idx !== 2'd0 || bus.mode !== 2'b10) begin
      errors++; $display("FAIL pulse_hold page=%0d mode=%b exp page=0 mode=10", bus.page_idx, bus.mode);
    end
    for (int c = 0; c < 14; c++) begin
      cycle();
      checks++;
      if (actv() !== expv()) begin
        errors++; $display("FAIL pulse c=%0d got=%h exp=%h", c, actv(), expv());
      end
    end
    checks++;
    if (bus.page_idx !== 2'd0 || bus.mode !== 2'b00) begin
      errors++; $display("FAIL pulse_exit page=%0d mode=%b exp page=0 mode=00", bus.page_idx, bus.mode);
    end
  endtask

  task automatic test_key_dwell();
    int pg;
    bit seen;
    seen = 1'b0;
    do_reset();
    bus.rot_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus.key_n = !(c >= 14 && c < 30);
      pg = m_page;
      cycle();
      checks++;
      if (actv() !== expv()) begin
        errors++; $display("FAIL key_dwell c=%0d got=%h exp=%h", c, actv(), expv());
      end
      if (m_coinc) begin
        seen = 1'b1;
        checks++;
        if (bus.page_idx !== 2'(pg + 1) || bus.mode !== 2'b01) begin
          errors++; $display("FAIL key_dwell_same page=%0d mode=%b exp page=%0d mode=01", bus.page_idx, bus.mode, (pg + 1) % 4);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL key_dwell_align got=no coincident edge exp=one");
    end
    bus.key_n = 1'b1;
  endtask

  task automatic test_random();
    int key_left, alert_left;
    key_left = 0; alert_left = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) bus.rot_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) bus.pages_reg1[$urandom_range(0, 3)*32 +: 32] = $urandom;
      if ($urandom_range(0, 19) == 0) bus.pages_reg2[$urandom_range(0, 3)*32 +: 32] = $urandom;
      if (key_left == 0) begin
        if (bus.key_n) begin
          bus.key_n = 1'b0;
          key_left  = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5) : $urandom_range(9, 30);
        end else begin
          bus.key_n = 1'b1;
          key_left  = $urandom_range(3, 40);
        end
      end
      if (alert_left == 0) begin
        if ($urandom_range(0, 3) != 0) begin
          bus.alert_req = 4'd0; alert_left = $urandom_range(20, 80);
        end else begin
          bus.alert_req = 4'($urandom_range(1, 15)); alert_left = $urandom_range(1, 40);
        end
      end
      key_left--; alert_left--;
      cycle();
      checks++;
      if (actv() !== expv()) begin
        errors++; $display("FAIL random c=%0d got=%h exp=%h", c, actv(), expv());
      end
    end
  endtask

  task automatic test_reset_mid_alert();
    bus.alert_req = 4'b0010;
    bus.key_n = 1'b0;
    repeat (6) cycle();
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (actv() !== 69'd0) begin
      errors++; $display("FAIL async_reset got=%h exp=0", actv());
    end
    bus.alert_req = 4'd0;
    bus.key_n = 1'b1;
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cycle();
      checks++;
      if (actv() !== expv()) begin
        errors++; $display("FAIL post_reset c=%0d got=%h exp=%h", c, actv(), expv());
      end
    end
    checks++;
    if (bus.mode !== 2'b00 || bus.page_idx !== 2'd0) begin
      errors++; $display("FAIL post_reset_idle mode=%b page=%0d exp mode=00 page=0", bus.mode, bus.page_idx);
    end
  endtask

  initial begin
    bus.pages_reg1 = '0;
    bus.pages_reg2 = '0;
    bus.key_n      = 1'b1;
    bus.alert_req  = 4'd0;
    bus.rot_en     = 1'b0;
    m_reset();
    test_reset();
    test_rotation();
    test_freeze();
    test_key();
    test_alert();
    test_priority();
    test_alert_pulse();
    test_key_dwell();
    test_random();
    test_reset_mid_alert();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
